wb_line_downsizer: RTL and testbench
====================================

# wb_line_downsizer

Wishbone width adapter between the memory controller's 128-bit cache-line bus and a 32-bit external memory bus. Each wide transfer is accepted as a single classic-cycle slave transaction and split into sequential narrow beats on a classic-cycle master port. Read beats are assembled into a full line before the wide acknowledge. Sits directly downstream of the memory controller's bus arbiter output.

## Interface
- ADDR_WIDTH, 32, byte address width on both ports
- WIDE_WIDTH, 128, upstream data width (cache line)
- NARROW_WIDTH, 32, downstream data width
- ADDR_GRANULARITY, 8, bits per address unit / select bit
- Derived: BEATS = WIDE_WIDTH/NARROW_WIDTH (4); NSEL = NARROW_WIDTH/ADDR_GRANULARITY (4); BEAT_IDX_W = clog2(BEATS)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_adr_i  in  ADDR_WIDTH  line address; low clog2(WIDE_WIDTH/ADDR_GRANULARITY) bits ignored
- s_dat_i  in  WIDE_WIDTH  write line
- s_dat_o  out  WIDE_WIDTH  read line
- s_we_i  in  1  write enable
- s_sel_i  in  WIDE_WIDTH/ADDR_GRANULARITY  byte selects
- s_stb_i, s_cyc_i  in  1  upstream strobe / cycle
- s_ack_o, s_err_o  out  1  upstream completion / error
- s_rty_o  out  1  tied 0
- m_adr_o  out  ADDR_WIDTH  beat address
- m_dat_o  out  NARROW_WIDTH  beat write data
- m_dat_i  in  NARROW_WIDTH  beat read data
- m_we_o  out  1; m_sel_o  out  NSEL
- m_stb_o, m_cyc_o  out  1  asserted together for every beat
- m_ack_i, m_err_i, m_rty_i  in  1  downstream responses

## Operation
- States: IDLE, BEAT, RESP.
- IDLE: when s_cyc_i & s_stb_i, latch aligned base address, s_we_i, s_sel_i, s_dat_i; set beat index to first beat (see Configuration); go BEAT. If no beat is to be issued, go RESP directly.
- BEAT: m_cyc_o = m_stb_o = 1; m_adr_o = base + idx*NSEL; m_sel_o = sel[idx*NSEL +: NSEL]; m_dat_o = wdata[idx*NARROW_WIDTH +: NARROW_WIDTH]; m_we_o = latched we.
  - m_ack_i: on read, store m_dat_i into rbuf slice idx. If idx is last beat, go RESP, else advance idx; m_stb_o stays high (back-to-back beats).
  - m_err_i (priority over ack): abort the remaining beats, set err flag, go RESP.
  - m_rty_i (no ack/err): re-present the same beat the next cycle; no retry limit.
- RESP: exactly one cycle of s_ack_o (or s_err_o if err flag set, never both); s_dat_o = rbuf; then IDLE, clearing err flag. Upstream deasserts s_stb_i in the cycle after ack, so IDLE does not re-accept it.
- rbuf cleared to 0 at every accept; write cycles return s_dat_o = 0.
- s_adr_i/s_dat_i changes while busy are ignored (latched copies used).

## Timing
- Reset (async assert): state IDLE; m_cyc_o, m_stb_o, m_we_o, s_ack_o, s_err_o = 0; m_adr_o, m_dat_o, m_sel_o, s_dat_o = 0. Mid-transaction reset drops m_cyc_o immediately; no upstream ack.
- Zero-wait downstream (ack in the same cycle as stb), full read line: s_stb_i sampled in cycle 0, beats in cycles 1-4, s_ack_o in cycle 5.
- Each downstream wait state adds one cycle; each rty adds one cycle.
- Outputs are registered from state/latched data; no combinational path from s_* inputs to m_* outputs.

## Configuration
- WB_DOWNSIZER_BEAT_SKIP_EN defined: beats whose NSEL-bit select slice is all-zero are skipped (idx advances to the next nonzero slice; the first beat is the lowest nonzero slice). An all-zero s_sel_i acks in RESP without any downstream cycle (s_ack_o at cycle 1).
- Undefined: all BEATS beats issued in order, including beats with m_sel_o = 0.

## Test plan
- Read line base 0x100, zero-wait slave returning 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> m_adr_o 0x100, 0x104, 0x108, 0x10C; s_dat_o = 0x44444444_33333333_22222222_11111111; s_ack_o high cycle 5 only.
- Write 0xDEADBEEF into word 2 of line 0x200, sel = 0x0F00, SKIP_EN defined -> single beat at 0x208, m_sel_o = 0xF, m_we_o = 1, s_ack_o at cycle 2; undefined -> 4 beats, only beat 2 has m_sel_o = 0xF.
- Read with 2 wait states on beat 1 and m_rty_i on beat 3 -> s_ack_o at cycle 8; beat 3 address repeated; data correct.
- m_err_i on beat 2 of a read -> beat 3 never issued, s_err_o one cycle, s_ack_o stays 0, next transaction accepted normally.
- rst low during beat 1 -> m_cyc_o/m_stb_o drop without waiting for clk; no s_ack_o; after release, new read completes correctly.

Source files
------------

// File: rtl/wb_line_downsizer_if.sv
`timescale 1ns/1ps
// Bus bundle for wb_line_downsizer: wide upstream Wishbone slave side plus narrow downstream master side.
// The "slave" modport is the adapter's view; "master" is the view of whatever drives and responds to it.
interface wb_line_downsizer_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int WIDE_WIDTH       = 128,
    parameter int NARROW_WIDTH     = 32,
    parameter int ADDR_GRANULARITY = 8
);
    localparam int WSEL = WIDE_WIDTH / ADDR_GRANULARITY;
    localparam int NSEL = NARROW_WIDTH / ADDR_GRANULARITY;

    logic [ADDR_WIDTH-1:0]   s_adr_i;
    logic [WIDE_WIDTH-1:0]   s_dat_i;
    logic [WIDE_WIDTH-1:0]   s_dat_o;
    logic                    s_we_i;
    logic [WSEL-1:0]         s_sel_i;
    logic                    s_stb_i;
    logic                    s_cyc_i;
    logic                    s_ack_o;
    logic                    s_err_o;
    logic                    s_rty_o;

    logic [ADDR_WIDTH-1:0]   m_adr_o;
    logic [NARROW_WIDTH-1:0] m_dat_o;
    logic [NARROW_WIDTH-1:0] m_dat_i;
    logic                    m_we_o;
    logic [NSEL-1:0]         m_sel_o;
    logic                    m_stb_o;
    logic                    m_cyc_o;
    logic                    m_ack_i;
    logic                    m_err_i;
    logic                    m_rty_i;

    modport slave (
        input  s_adr_i, s_dat_i, s_we_i, s_sel_i, s_stb_i, s_cyc_i,
        output s_dat_o, s_ack_o, s_err_o, s_rty_o,
        output m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
        input  m_dat_i, m_ack_i, m_err_i, m_rty_i
    );

    modport master (
        output s_adr_i, s_dat_i, s_we_i, s_sel_i, s_stb_i, s_cyc_i,
        input  s_dat_o, s_ack_o, s_err_o, s_rty_o,
        input  m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o,
        output m_dat_i, m_ack_i, m_err_i, m_rty_i
    );
endinterface

// File: rtl/wb_line_downsizer.sv
`timescale 1ns/1ps
// Splits one wide classic-cycle Wishbone line transfer into sequential narrow beats (reads reassembled).
// Latency: accept + one cycle per beat (+1 per wait/retry) + one response cycle; upstream is held until then.
// WB_DOWNSIZER_BEAT_SKIP_EN: beats whose byte-select slice is all zero are not issued downstream.
module wb_line_downsizer #(
    parameter int ADDR_WIDTH       = 32,
    parameter int WIDE_WIDTH       = 128,
    parameter int NARROW_WIDTH     = 32,
    parameter int ADDR_GRANULARITY = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_line_downsizer_if.slave bus
);
    localparam int BEATS      = WIDE_WIDTH / NARROW_WIDTH;
    localparam int NSEL       = NARROW_WIDTH / ADDR_GRANULARITY;
    localparam int WSEL       = WIDE_WIDTH / ADDR_GRANULARITY;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int OFF_W      = $clog2(WSEL);
    localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic                    r_we;
    logic [WSEL-1:0]         r_sel;
    logic [WIDE_WIDTH-1:0]   r_wdat;
    logic [WIDE_WIDTH-1:0]   r_rbuf;
    logic [BEAT_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic                    r_err;
    logic                    w_accept, w_beat_ack, w_beat_err, w_in_beat;
    logic [BEAT_IDX_W:0]     w_first, w_next;   // {found, beat index}
    logic                    w_unused_adr;

    assign w_unused_adr = ^bus.s_adr_i[OFF_W-1:0];

`ifdef WB_DOWNSIZER_BEAT_SKIP_EN
    function automatic logic [BEAT_IDX_W:0] find_beat(input logic [WSEL-1:0] sel, input int from);
        logic [BEAT_IDX_W:0] res;
        res = '0;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (i >= from && sel[i*NSEL +: NSEL] != '0)
                res = {1'b1, BEAT_IDX_W'(i)};
        end
        return res;
    endfunction

    assign w_first = find_beat(bus.s_sel_i, 0);
    assign w_next  = find_beat(r_sel, int'(r_idx) + 1);
`else
    assign w_first = {1'b1, {BEAT_IDX_W{1'b0}}};
    assign w_next  = {r_idx != LAST_IDX, r_idx + 1'b1};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_accept    = 1'b0;
        w_beat_ack  = 1'b0;
        w_beat_err  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.s_cyc_i && bus.s_stb_i) begin
                    w_accept = 1'b1;
                    if (w_first[BEAT_IDX_W]) begin
                        w_state_nxt = BEAT;
                        w_idx_nxt   = w_first[BEAT_IDX_W-1:0];
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            BEAT: begin
                // err wins over ack; a retry or wait simply re-presents the same beat
                if (bus.m_err_i) begin
                    w_beat_err  = 1'b1;
                    w_state_nxt = RESP;
                end else if (bus.m_ack_i) begin
                    w_beat_ack = 1'b1;
                    if (w_next[BEAT_IDX_W])
                        w_idx_nxt = w_next[BEAT_IDX_W-1:0];
                    else
                        w_state_nxt = RESP;
                end else if (bus.m_rty_i) begin
                    w_state_nxt = BEAT;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base <= '0;
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_wdat <= '0;
            r_rbuf <= '0;
            r_idx  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_idx <= w_idx_nxt;
            if (w_accept) begin
                r_base <= {bus.s_adr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                r_we   <= bus.s_we_i;
                r_sel  <= bus.s_sel_i;
                r_wdat <= bus.s_dat_i;
                r_rbuf <= '0;
                r_err  <= 1'b0;
            end
            if (w_beat_ack && !r_we)
                r_rbuf[r_idx*NARROW_WIDTH +: NARROW_WIDTH] <= bus.m_dat_i;
            if (w_beat_err)
                r_err <= 1'b1;
            else if (r_state == RESP)
                r_err <= 1'b0;
        end
    end

    // Downstream outputs depend only on state and latched copies, never on live s_* inputs
    assign w_in_beat   = (r_state == BEAT);
    assign bus.m_cyc_o = w_in_beat;
    assign bus.m_stb_o = w_in_beat;
    assign bus.m_we_o  = w_in_beat & r_we;
    assign bus.m_adr_o = w_in_beat ? r_base + ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(NSEL) : '0;
    assign bus.m_sel_o = w_in_beat ? r_sel[r_idx*NSEL +: NSEL] : '0;
    assign bus.m_dat_o = w_in_beat ? r_wdat[r_idx*NARROW_WIDTH +: NARROW_WIDTH] : '0;

    assign bus.s_ack_o = (r_state == RESP) & ~r_err;
    assign bus.s_err_o = (r_state == RESP) & r_err;
    assign bus.s_rty_o = 1'b0;
    assign bus.s_dat_o = r_rbuf;
endmodule

// File: tb/tb_wb_line_downsizer.sv
`timescale 1ns/1ps
// Bench for wb_line_downsizer: vector table of line transfers against a responding narrow memory model,
// with expected downstream beats held in a scoreboard queue, plus a mid-transaction reset sequence.
module tb_wb_line_downsizer;
`ifdef WB_DOWNSIZER_BEAT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam logic [1:0] R_ACK = 2'd0, R_WAIT = 2'd1, R_RTY = 2'd2, R_ERR = 2'd3;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic         we;
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic [127:0] wdat;
        logic [15:0]  codes;
        int           ncodes;
        logic [127:0] exp_rdata;
        logic         exp_err;
        int           exp_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    beat_t       sb[$];
    logic [1:0]  resp_q[$];
    logic [31:0] mem [0:1023];
    vec_t        vecs [8];

    wb_line_downsizer_if bus ();
    wb_line_downsizer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Narrow memory slave: decides each beat's response on the falling edge
    always @(negedge clk) begin
        logic [1:0] code;
        beat_t      got;
        bus.m_ack_i = 1'b0;
        bus.m_err_i = 1'b0;
        bus.m_rty_i = 1'b0;
        bus.m_dat_i = $urandom;
        if (rst && bus.m_stb_o) begin
            check("cyc_with_stb", bus.m_cyc_o, 1'b1);
            code = (resp_q.size() != 0) ? resp_q.pop_front() : R_ACK;
            check("beat_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                got = '{adr: bus.m_adr_o, we: bus.m_we_o, sel: bus.m_sel_o,
                        dat: bus.m_we_o ? bus.m_dat_o : 32'h0};
                check("beat", got, sb[0]);
            end
            case (code)
                R_ACK: begin
                    bus.m_ack_i = 1'b1;
                    if (bus.m_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.m_sel_o[b])
                                mem[bus.m_adr_o[11:2]][b*8 +: 8] = bus.m_dat_o[b*8 +: 8];
                    end else begin
                        bus.m_dat_i = mem[bus.m_adr_o[11:2]];
                    end
                    if (sb.size() != 0) void'(sb.pop_front());
                end
                R_RTY: bus.m_rty_i = 1'b1;
                R_ERR: begin
                    bus.m_err_i = 1'b1;
                    sb.delete();
                end
                default: ;
            endcase
        end
    end

    function automatic void push_expect(input vec_t v);
        logic [3:0] s;
        for (int i = 0; i < 4; i++) begin
            s = v.sel[i*4 +: 4];
            if (!(SKIP && s == 4'h0))
                sb.push_back('{adr: {v.adr[31:4], 4'h0} + 32'(i * 4), we: v.we, sel: s,
                               dat: v.we ? v.wdat[i*32 +: 32] : 32'h0});
        end
    endfunction

    task automatic run_txn(input vec_t v, input string nm);
        int cyc;
        bit got;
        push_expect(v);
        for (int i = 0; i < v.ncodes; i++) resp_q.push_back(v.codes[2*i +: 2]);
        @(negedge clk);
        bus.s_adr_i = v.adr;
        bus.s_dat_i = v.wdat;
        bus.s_sel_i = v.sel;
        bus.s_we_i  = v.we;
        bus.s_cyc_i = 1'b1;
        bus.s_stb_i = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus.s_adr_i = v.adr ^ 32'h0000_0F00;
                bus.s_dat_i = ~v.wdat;
            end
            got = bus.s_ack_o | bus.s_err_o;
        end
        check({nm, "_done"}, got, 1'b1);
        check({nm, "_cycle"}, cyc, v.exp_cyc);
        check({nm, "_ack_err"}, {bus.s_ack_o, bus.s_err_o}, v.exp_err ? 2'b01 : 2'b10);
        if (!v.exp_err) check({nm, "_rdata"}, bus.s_dat_o, v.exp_rdata);
        bus.s_cyc_i = 1'b0;
        bus.s_stb_i = 1'b0;
        @(negedge clk);
        check({nm, "_one_cycle"}, {bus.s_ack_o, bus.s_err_o, bus.m_cyc_o}, 3'b000);
        check({nm, "_all_beats"}, sb.size(), 0);
        resp_q.delete();
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        bus.s_adr_i = '0; bus.s_dat_i = '0; bus.s_sel_i = '0; bus.s_we_i = 1'b0;
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            mem[(32'h100 >> 2) + k] = {8{4'(k + 1)}};
            mem[(32'h200 >> 2) + k] = 32'h5555_0000 + 32'(k);
            mem[(32'h300 >> 2) + k] = 32'h6666_0000 + 32'(k);
        end

        vecs[0] = '{we: 0, adr: 32'h100, sel: 16'hFFFF, wdat: '0, codes: 16'h0, ncodes: 0,
                    exp_rdata: 128'h44444444_33333333_22222222_11111111, exp_err: 0, exp_cyc: 5};
        vecs[1] = '{we: 1, adr: 32'h200, sel: 16'h0F00,
                    wdat: 128'hAAAA0003_DEADBEEF_AAAA0001_AAAA0000, codes: 16'h0, ncodes: 0,
                    exp_rdata: '0, exp_err: 0, exp_cyc: SKIP ? 2 : 5};
        vecs[2] = '{we: 0, adr: 32'h200, sel: 16'hFFFF, wdat: '0, codes: 16'h0814, ncodes: 7,
                    exp_rdata: 128'h55550003_DEADBEEF_55550001_55550000, exp_err: 0, exp_cyc: 8};
        vecs[3] = '{we: 0, adr: 32'h300, sel: 16'hFFFF, wdat: '0, codes: 16'h0030, ncodes: 3,
                    exp_rdata: '0, exp_err: 1, exp_cyc: 4};
        vecs[4] = '{we: 0, adr: 32'h30C, sel: 16'h00F0, wdat: '0, codes: 16'h0, ncodes: 0,
                    exp_rdata: SKIP ? 128'h00000000_00000000_66660001_00000000
                                    : 128'h66660003_66660002_66660001_66660000,
                    exp_err: 0, exp_cyc: SKIP ? 2 : 5};
        vecs[5] = '{we: 0, adr: 32'h100, sel: 16'h0000, wdat: '0, codes: 16'h0, ncodes: 0,
                    exp_rdata: SKIP ? 128'h0 : 128'h44444444_33333333_22222222_11111111,
                    exp_err: 0, exp_cyc: SKIP ? 1 : 5};
        vecs[6] = '{we: 1, adr: 32'h400, sel: 16'hF0F3,
                    wdat: 128'h01234567_89ABCDEF_FEDCBA98_76543210, codes: 16'h0002, ncodes: 1,
                    exp_rdata: '0, exp_err: 0, exp_cyc: SKIP ? 5 : 6};
        vecs[7] = '{we: 0, adr: 32'h400, sel: 16'hFFFF, wdat: '0, codes: 16'h0, ncodes: 0,
                    exp_rdata: 128'h01234567_00000000_FEDCBA98_00003210, exp_err: 0, exp_cyc: 5};

        #1;
        check("reset_ctrl", {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.s_ack_o, bus.s_err_o, bus.s_rty_o},
              6'b0);
        check("reset_data", {bus.m_adr_o, bus.m_dat_o, bus.m_sel_o}, 68'h0);
        check("reset_sdat", bus.s_dat_o, 128'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted while the second beat of a read is waiting on the slave
        push_expect(vecs[0]);
        resp_q.push_back(R_ACK);
        repeat (6) resp_q.push_back(R_WAIT);
        @(negedge clk);
        bus.s_adr_i = 32'h100; bus.s_sel_i = 16'hFFFF; bus.s_we_i = 1'b0;
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_beat_active", {bus.m_stb_o, bus.m_adr_o}, {1'b1, 32'h104});
        #2 rst = 1'b0;
        #1;
        check("rst_drops_cyc_stb", {bus.m_cyc_o, bus.m_stb_o}, 2'b00);
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        resp_q.delete();
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_ack", {bus.s_ack_o, bus.s_err_o, bus.m_cyc_o}, 3'b000);
        end
        rst = 1'b1;
        run_txn(vecs[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
